// File: rtl/mips_prefetch_queue.sv
// Instruction prefetch queue for the mips32 fetch stage: issues word reads, buffers
// returned words in a small FIFO and presents {ir, npc} to decode with valid/ready.
module mips_prefetch_queue #(
  parameter int unsigned    DEPTH    = 4,
  parameter int unsigned    AW       = 10,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter logic [5:0]     HLT_OP   = 6'b111111
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     imem_rvalid,
  input  logic                     redir_valid,
  input  logic [AW-1:0]            redir_pc,
  output logic [31:0]              ir_out,
  output logic [AW-1:0]            npc_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     halt_seen,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   req_addr_q, req_addr_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     ir_mem_q [DEPTH];
  logic [31:0]     ir_mem_d [DEPTH];
  logic [AW-1:0]   npc_mem_q [DEPTH];
  logic [AW-1:0]   npc_mem_d [DEPTH];

  logic            resp_live;
  logic            hlt_arriving;
  logic            push;
  logic            pop;
  logic [CW:0]     occupancy;

  always_comb begin
    // A response only counts if its request was issued last cycle and not killed since.
    resp_live    = imem_rvalid && inflight_q;
    hlt_arriving = resp_live && (imem_rdata[31:26] == HLT_OP);
    push         = resp_live && !redir_valid;
    valid_out    = (count_q != '0);
    pop          = valid_out && ready_in;
    occupancy    = {1'b0, count_q} + (CW + 1)'(inflight_q);
    // The word behind an arriving HLT is never requested.
    imem_req     = (state_q == S_RUN) && !redir_valid && !hlt_arriving &&
                   (occupancy < (CW + 1)'(DEPTH));
    imem_addr    = pc_q;
    ir_out       = ir_mem_q[head_q];
    npc_out      = npc_mem_q[head_q];
    halt_seen    = (state_q == S_HALTED);
    count_out    = count_q;

    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inflight_d = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ir_mem_d   = ir_mem_q;
    npc_mem_d  = npc_mem_q;

    if (redir_valid) begin
      state_d = S_RUN;
      pc_d    = redir_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (imem_req) begin
        pc_d       = pc_q + AW'(1);
        req_addr_d = pc_q;
        inflight_d = 1'b1;
      end
      if (push) begin
        ir_mem_d[tail_q]  = imem_rdata;
        npc_mem_d[tail_q] = req_addr_q + AW'(1);
        tail_d            = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (hlt_arriving) begin
        state_d = S_HALTED;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i]  <= '0;
        npc_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ir_mem_q   <= ir_mem_d;
      npc_mem_q  <= npc_mem_d;
    end
  end

endmodule

// File: tb/tb_mips_prefetch_queue.sv
// Bench for mips_prefetch_queue: directed scenarios plus a randomized phase, every
// cycle compared against a queue-based reference model of the fetch front end.
module tb_mips_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          imem_rvalid = 1'b0;
  logic          redir_valid = 1'b0;
  logic [AW-1:0] redir_pc = '0;
  logic [31:0]   ir_out;
  logic [AW-1:0] npc_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic          halt_seen;
  logic [2:0]    count_out;

  always #5 clk1 = ~clk1;

  mips_prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .ir_out(ir_out), .npc_out(npc_out), .valid_out(valid_out),
    .ready_in(ready_in), .halt_seen(halt_seen), .count_out(count_out)
  );

  // Instruction memory: answers every request one cycle later, never stalls.
  logic [31:0] mem [1024];
  always @(posedge clk1) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= mem[imem_addr];
  end

  typedef struct {
    logic [31:0]   ir;
    logic [AW-1:0] npc;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc;
  logic          m_halted;
  logic          m_pend;
  logic [AW-1:0] m_pend_addr;
  logic          m_fresh;
  logic          req6;
  int            ncmp = 0;
  int            nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc        = '0;
    m_halted    = 1'b0;
    m_pend      = 1'b0;
    m_pend_addr = '0;
    m_fresh     = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
  task automatic step(input logic rst, input logic rdv, input logic [AW-1:0] rpc,
                      input logic rdy);
    logic exp_req;
    logic hlt_next;
    logic hlt;
    ent_t e;
    @(negedge clk1);
    rst_n       = rst;
    redir_valid = rdv;
    redir_pc    = rpc;
    ready_in    = rdy;
    #1;
    hlt_next = m_pend && (mem[m_pend_addr][31:26] == 6'h3f);
    exp_req  = !m_halted && !rdv && !hlt_next && ((mq.size() + int'(m_pend)) < DEPTH);
    chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
    chk("count_out", 32'(count_out), 32'(mq.size()));
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("halt_seen", 32'(halt_seen), 32'(m_halted));
    if (mq.size() != 0) begin
      chk("ir_out", ir_out, mq[0].ir);
      chk("npc_out", 32'(npc_out), 32'(mq[0].npc));
    end else if (m_fresh) begin
      chk("ir_out_rst", ir_out, 32'h0);
      chk("npc_out_rst", 32'(npc_out), 32'h0);
    end
    if (imem_req && imem_addr == 10'd6) req6 = 1'b1;
    @(posedge clk1);
    if (!rst) begin
      model_reset();
    end else if (rdv) begin
      mq.delete();
      m_pend   = 1'b0;
      m_pc     = rpc;
      m_halted = 1'b0;
    end else begin
      hlt = 1'b0;
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_pend) begin
        e.ir  = mem[m_pend_addr];
        e.npc = m_pend_addr + 10'd1;
        mq.push_back(e);
        m_fresh = 1'b0;
        hlt = (e.ir[31:26] == 6'h3f);
        if (hlt) m_halted = 1'b1;
      end
      m_pend = exp_req;
      if (exp_req) begin
        m_pend_addr = m_pc;
        m_pc        = m_pc + 10'd1;
      end
    end
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, rdy);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom & 32'hf7ff_ffff;
      if (i >= 64 && (i % 37) == 36) mem[i] = 32'hfc00_0000 | (32'(i) & 32'hffff);
    end
    mem[0] = 32'h2001000a;
    mem[1] = 32'h20020014;
    mem[2] = 32'h20030019;
    mem[3] = 32'h00222000;
    mem[4] = 32'h00000020;
    mem[5] = 32'hfc000000;
    req6   = 1'b0;

    repeat (2) @(posedge clk1);
    model_reset();
    step(1'b0, 1'b0, '0, 1'b1);

    // Reset then run: first word visible two cycles after rst_n rises, then halt at 5.
    run(2, 1'b1);
    #1;
    chk("first_valid", 32'(valid_out), 32'h1);
    chk("first_ir", ir_out, 32'h2001000a);
    run(14, 1'b1);
    chk("halted", 32'(halt_seen), 32'h1);

    // Backpressure: queue fills to DEPTH with no extra push, then drains in order.
    step(1'b1, 1'b1, 10'd0, 1'b0);
    run(10, 1'b0);
    #1;
    chk("bp_full", 32'(count_out), 32'd4);
    chk("bp_noreq", 32'(imem_req), 32'h0);
    run(12, 1'b1);
    chk("no_req6", 32'(req6), 32'h0);

    // Redirect with three words queued and one in flight.
    step(1'b1, 1'b1, 10'd0, 1'b0);
    for (int i = 0; i < 10 && mq.size() < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 10'd20, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    #1;
    chk("redir_ir", ir_out, mem[20]);
    chk("redir_npc", 32'(npc_out), 32'd21);
    run(8, 1'b1);

    // Redirect coinciding with a pop and an arriving response.
    for (int i = 0; i < 20 && !(mq.size() != 0 && m_pend); i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 10'd100, 1'b1);
    #1;
    chk("simul_count", 32'(count_out), 32'h0);
    run(6, 1'b1);

    // Address wrap 1023 -> 0.
    step(1'b1, 1'b1, 10'd1023, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    #1;
    chk("wrap_npc", 32'(npc_out), 32'h0);
    run(6, 1'b1);

    // Reset while the queue is full.
    step(1'b1, 1'b1, 10'd0, 1'b0);
    run(8, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("rst_count", 32'(count_out), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_ir", ir_out, 32'h0);
    run(10, 1'b1);

    // Randomized traffic: backpressure, redirects and occasional resets.
    for (int i = 0; i < 600; i++) begin
      int r;
      logic rdy;
      r   = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 3) != 0);
      if (r == 0)
        step(1'b0, 1'b0, '0, rdy);
      else if (r < 7)
        step(1'b1, 1'b1, 10'($urandom_range(0, 1023)), rdy);
      else
        step(1'b1, 1'b0, '0, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
